double_exp_sequencer: RTL and testbench

DOUBLE_EXP_SEQUENCER -- requirements
Module: double_exp_sequencer

---
 rtl/double_exp_sequencer.sv | 136 +++++++++++++
 tb/tb_double_exp_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/double_exp_sequencer.sv
`timescale 1ns/1ps
// Sequences one operand through a carry-save exponentiation core: load strobe, setup gap, operand, wait for done.
// Latency: ack in the request cycle, operand LOAD_CYCLES+SETUP_CYCLES+1 cycles later, vld one cycle after the dn edge.
// Backpressure: a request is taken only in IDLE; req in any other state is ignored (no ack) and must be held to retry.
module double_exp_sequencer #(
    parameter int LOAD_CYCLES  = 8,
    parameter int SETUP_CYCLES = 6,
    parameter int TIMEOUT      = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [0:7] x,
    output logic       ack,
    output logic       busy,
    output logic       ld,
    output logic [0:7] xs,
    output logic [0:7] xc,
    input  logic       dn,
    input  logic [0:7] ys,
    input  logic [0:7] yc,
    output logic       vld,
    output logic [0:7] y,
    output logic       err
);
    localparam int MAX_LS = (LOAD_CYCLES > SETUP_CYCLES) ? LOAD_CYCLES : SETUP_CYCLES;
    localparam int MAX_C  = (MAX_LS > TIMEOUT) ? MAX_LS : TIMEOUT;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] LD_LAST = CW'(LOAD_CYCLES - 1);
    localparam logic [CW-1:0] SU_LAST = CW'(SETUP_CYCLES - 1);
    // WAIT is entered with count 1; leaving at TIMEOUT-1 puts ERR exactly TIMEOUT cycles after PRESENT.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, PRESENT, WAIT, DONE, ERR} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [0:7]    xr;
    logic          dn_q;
    logic          dn_rise;

    // The core's result is valid only on a fresh low-to-high transition of dn.
    assign dn_rise = dn & ~dn_q;
    // The core is always fed in carry-save form with a zero carry word.
    assign xc = 8'h00;

    // State and phase counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Operand capture, dn history and result resolution of the carry-save pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xr   <= 8'h00;
            dn_q <= 1'b0;
            y    <= 8'h00;
        end else begin
            dn_q <= dn;
            if (state == IDLE && req) xr <= x;
            if (state == WAIT && dn_rise) y <= ys + yc;
        end
    end

    // Next-state, counter and strobe decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack       = 1'b0;
        busy      = 1'b1;
        ld        = 1'b0;
        xs        = 8'h00;
        vld       = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req) begin
                    ack       = 1'b1;
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                end
            end
            LOAD: begin
                ld = 1'b1;
                if (cnt == LD_LAST) begin
                    state_nxt = SETUP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SETUP: begin
                if (cnt == SU_LAST) begin
                    state_nxt = PRESENT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESENT: begin
                xs        = xr;
                state_nxt = WAIT;
                cnt_nxt   = CW'(1);
            end
            WAIT: begin
                // A dn edge on the last allowed cycle still completes normally.
                if (dn_rise) begin
                    state_nxt = DONE;
                end else if (cnt >= TO_LAST) begin
                    state_nxt = ERR;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                vld       = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                err       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // State is already IDLE under reset; only the req-driven ack needs masking.
        if (rst) ack = 1'b0;
    end
endmodule

// File: tb/tb_double_exp_sequencer.sv
`timescale 1ns/1ps
module tb_double_exp_sequencer;
    localparam int L = 8;
    localparam int S = 6;
    localparam int P = L + S + 1;   // cycles from acceptance to operand presentation

    logic       clk = 1'b0;
    logic       rst, req, dn;
    logic [0:7] x, ys, yc;

    logic       a_ack, a_busy, a_ld, a_vld, a_err;
    logic [0:7] a_xs, a_xc, a_y;
    logic       b_ack, b_busy, b_ld, b_vld, b_err;
    logic [0:7] b_xs, b_xc, b_y;

    double_exp_sequencer dut_a (
        .clk(clk), .rst(rst), .req(req), .x(x), .ack(a_ack), .busy(a_busy), .ld(a_ld),
        .xs(a_xs), .xc(a_xc), .dn(dn), .ys(ys), .yc(yc), .vld(a_vld), .y(a_y), .err(a_err)
    );

    double_exp_sequencer #(.TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .req(req), .x(x), .ack(b_ack), .busy(b_busy), .ld(b_ld),
        .xs(b_xs), .xc(b_xc), .dn(dn), .ys(ys), .yc(yc), .vld(b_vld), .y(b_y), .err(b_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic sel_b;

    // Reference model: an operation is a timeline measured from its acceptance cycle.
    logic       m_act;
    int         m_t;      // cycles since acceptance
    int         m_fin;    // completion (vld) cycle, -1 until a dn edge lands in the window
    int         m_to;
    logic [0:7] m_x, m_y;
    logic       m_dnp;
    logic       exp_ack, exp_busy, exp_ld, exp_vld, exp_err;
    logic [0:7] exp_xs;

    function automatic logic [28:0] obs();
        if (sel_b) return {b_ack, b_busy, b_ld, b_xs, b_xc, b_vld, b_err, b_y};
        return {a_ack, a_busy, a_ld, a_xs, a_xc, a_vld, a_err, a_y};
    endfunction

    function automatic logic [28:0] expv();
        return {exp_ack, exp_busy, exp_ld, exp_xs, 8'h00, exp_vld, exp_err, m_y};
    endfunction

    task automatic model_clear();
        m_act = 1'b0; m_t = 0; m_fin = -1; m_x = 8'h00; m_y = 8'h00; m_dnp = 1'b0;
    endtask

    // Apply this cycle's inputs and derive the expected outputs from the timeline.
    task automatic drive(input logic r, input logic [0:7] xv, input logic d,
                         input logic [0:7] ysv, input logic [0:7] ycv);
        req = r; x = xv; dn = d; ys = ysv; yc = ycv;
        #1;
        exp_ack  = !m_act && r;
        exp_busy = m_act;
        exp_ld   = m_act && m_t >= 1 && m_t <= L;
        exp_xs   = (m_act && m_t == P) ? m_x : 8'h00;
        exp_vld  = m_act && m_t == m_fin;
        exp_err  = m_act && m_fin < 0 && m_t == P + m_to;
    endtask

    // Advance the model across the clock edge, then move to just after the edge.
    task automatic adv();
        if (!m_act) begin
            if (req) begin
                m_act = 1'b1; m_t = 0; m_x = x; m_fin = -1;
            end
        end else if (m_t == m_fin || (m_fin < 0 && m_t == P + m_to)) begin
            m_act = 1'b0;
        end else if (m_fin < 0 && m_t > P && m_t < P + m_to && dn && !m_dnp) begin
            m_fin = m_t + 1;
            m_y   = ys + yc;
        end
        if (m_act) m_t++;
        m_dnp = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; dn = 1'b1; x = 8'hFF; ys = 8'hFF; yc = 8'hFF;
        #1;
        vectors++;
        if ({a_ack, a_busy, a_ld, a_xs, a_xc, a_vld, a_err, a_y} !== 29'd0) begin
            miscompares++; $display("FAIL reset_a got %h want 0", {a_ack, a_busy, a_ld, a_xs, a_xc, a_vld, a_err, a_y});
        end
        vectors++;
        if ({b_ack, b_busy, b_ld, b_xs, b_xc, b_vld, b_err, b_y} !== 29'd0) begin
            miscompares++; $display("FAIL reset_b got %h want 0", {b_ack, b_busy, b_ld, b_xs, b_xc, b_vld, b_err, b_y});
        end
        release_rst();
        // Idle, then an operation cut short by reset in LOAD.
        for (int c = 0; c < 8; c++) begin
            drive(c == 3, 8'(c + 8'h40), 1'b0, 8'h00, 8'h00);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL reset_idle c=%0d got %h want %h", c, obs(), expv());
            end
            adv();
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (obs() !== 29'd0) begin
            miscompares++; $display("FAIL reset_load got %h want 0", obs());
        end
        release_rst();
    endtask

    task automatic test_nominal();
        for (int c = 0; c < 60; c++) begin
            drive(c == 0, (c == 0) ? 8'h5A : 8'($urandom), c >= 55 && c < 58,
                  (c == 55) ? 8'h30 : 8'($urandom), (c == 55) ? 8'h0C : 8'($urandom));
            vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL nominal c=%0d got %h want %h", c, obs(), expv());
            end
            adv();
        end
        vectors++;
        if (a_y !== 8'h3C) begin
            miscompares++; $display("FAIL nominal_y got %h want 3c", a_y);
        end
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 25; c++) begin
            drive(c == 0, 8'h81, c >= 20 && c < 22,
                  (c == 20) ? 8'hF0 : 8'($urandom), (c == 20) ? 8'h20 : 8'($urandom));
            vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL wrap c=%0d got %h want %h", c, obs(), expv());
            end
            adv();
        end
        vectors++;
        if (a_y !== 8'h10) begin
            miscompares++; $display("FAIL wrap_y got %h want 10", a_y);
        end
    endtask

    task automatic test_busy_guard();
        for (int c = 0; c < 40; c++) begin
            drive(c == 0 || c == 10 || c == 30, 8'($urandom), c == 3 || c == 4 || (c >= 35 && c < 37),
                  (c == 35) ? 8'h12 : 8'($urandom), (c == 35) ? 8'h34 : 8'($urandom));
            vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL busy_guard c=%0d got %h want %h", c, obs(), expv());
            end
            adv();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 46; c++) begin
            drive(c <= 20, 8'($urandom), (c >= 18 && c < 20) || (c >= 40 && c < 42),
                  8'($urandom), 8'($urandom));
            vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL back_to_back c=%0d got %h want %h", c, obs(), expv());
            end
            adv();
        end
    endtask

    task automatic test_abort();
        int ld_cnt;
        for (int c = 0; c < 25; c++) begin
            drive(c == 0, 8'h77, 1'b0, 8'($urandom), 8'($urandom));
            vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL abort_pre c=%0d got %h want %h", c, obs(), expv());
            end
            adv();
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (obs() !== 29'd0) begin
            miscompares++; $display("FAIL abort_rst got %h want 0", obs());
        end
        release_rst();
        ld_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            drive(c == 8, (c == 8) ? 8'h01 : 8'($urandom), c >= 3 && c < 5, 8'($urandom), 8'($urandom));
            vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL abort_post c=%0d got %h want %h", c, obs(), expv());
            end
            if (a_ld) ld_cnt++;
            adv();
        end
        vectors++;
        if (ld_cnt != L) begin
            miscompares++; $display("FAIL abort_ld_count got %0d want %0d", ld_cnt, L);
        end
    endtask

    task automatic test_timeout();
        rst = 1'b1;
        #1;
        release_rst();
        sel_b = 1'b1;
        m_to = 16;
        // Completion, then a request whose core never answers.
        for (int c = 0; c < 58; c++) begin
            drive(c == 0 || c == 23, 8'($urandom), c == 20,
                  (c == 20) ? 8'h9C : 8'($urandom), (c == 20) ? 8'h71 : 8'($urandom));
            vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL timeout c=%0d got %h want %h", c, obs(), expv());
            end
            adv();
        end
        vectors++;
        if (b_y !== 8'h0D) begin
            miscompares++; $display("FAIL timeout_y got %h want 0d", b_y);
        end
        // dn edge on the final WAIT cycle wins over the timeout.
        for (int c = 0; c < 34; c++) begin
            drive(c == 0, 8'($urandom), c == P + 15, 8'($urandom), 8'($urandom));
            vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL timeout_edge c=%0d got %h want %h", c, obs(), expv());
            end
            adv();
        end
        // dn already high on WAIT entry is not an edge.
        for (int c = 0; c < 34; c++) begin
            drive(c == 0, 8'($urandom), c >= 10, 8'($urandom), 8'($urandom));
            vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL timeout_level c=%0d got %h want %h", c, obs(), expv());
            end
            adv();
        end
    endtask

    task automatic test_random();
        for (int pass = 0; pass < 2; pass++) begin
            rst = 1'b1;
            #1;
            release_rst();
            sel_b = (pass == 1);
            m_to  = (pass == 1) ? 16 : 4096;
            for (int c = 0; c < 300; c++) begin
                drive($urandom_range(0, 3) == 0, 8'($urandom),
                      (pass == 1) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 9) == 0),
                      8'($urandom), 8'($urandom));
                vectors++;
                if (obs() !== expv()) begin
                    miscompares++; $display("FAIL random p=%0d c=%0d got %h want %h", pass, c, obs(), expv());
                end
                adv();
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = 1'b0; dn = 1'b0; x = 8'h00; ys = 8'h00; yc = 8'h00;
        sel_b = 1'b0;
        m_to = 4096;
        model_clear();
        test_reset();
        test_nominal();
        test_wrap();
        test_busy_guard();
        test_back_to_back();
        test_abort();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
